// File: rtl/mvu_agu.sv
// Address generation unit for one MVU memory stream: walks a 3-deep nested loop
// of signed strides from a latched job configuration, one address per granted cycle.
module mvu_agu #(
  parameter int BADDR   = 15,
  parameter int BSTRIDE = 15,
  parameter int BLENGTH = 15,
  parameter int BCNTDWN = 29
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BADDR-1:0]   baseaddr,
  input  logic [BSTRIDE-1:0] stride_0,
  input  logic [BSTRIDE-1:0] stride_1,
  input  logic [BSTRIDE-1:0] stride_2,
  input  logic [BLENGTH-1:0] length_0,
  input  logic [BLENGTH-1:0] length_1,
  input  logic [BLENGTH-1:0] length_2,
  input  logic [BCNTDWN-1:0] countdown,
  output logic               addr_en,
  input  logic               addr_grnt,
  output logic [BADDR-1:0]   addr_out,
  output logic [2:0]         loop_end,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [BCNTDWN-1:0] CNT_ONE = 1;
  localparam logic [BLENGTH-1:0] LEN_ONE = 1;

  state_t state, state_next;

  logic [BADDR-1:0]   base_q, addr_q;
  logic [BSTRIDE-1:0] s0_q, s1_q, s2_q;
  logic [BLENGTH-1:0] l0_q, l1_q, l2_q;
  logic [BLENGTH-1:0] i0, i1, i2;
  logic [BCNTDWN-1:0] count_q;
  logic               xfer, last0, last1, last2;

  // Strides may be wider or narrower than the address; both cases reduce mod 2^BADDR.
  function automatic logic [BADDR-1:0] sext(input logic [BSTRIDE-1:0] s);
    return BADDR'({{BADDR{s[BSTRIDE-1]}}, s});
  endfunction

  assign xfer  = (state == RUN) && addr_grnt;
  assign last0 = (i0 == l0_q);
  assign last1 = last0 && (i1 == l1_q);
  assign last2 = last1 && (i2 == l2_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (countdown == '0) ? DONE : RUN;
      RUN:  if (xfer && count_q == CNT_ONE) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      addr_q  <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      l0_q    <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      i0      <= '0;
      i1      <= '0;
      i2      <= '0;
      count_q <= '0;
    end else if (state == IDLE && start) begin
      base_q  <= baseaddr;
      addr_q  <= baseaddr;
      s0_q    <= stride_0;
      s1_q    <= stride_1;
      s2_q    <= stride_2;
      l0_q    <= length_0;
      l1_q    <= length_1;
      l2_q    <= length_2;
      i0      <= '0;
      i1      <= '0;
      i2      <= '0;
      count_q <= countdown;
    end else if (xfer && count_q != CNT_ONE) begin
      count_q <= count_q - CNT_ONE;
      // Innermost level that still has iterations left advances; all below it wrap.
      if (!last0) begin
        i0     <= i0 + LEN_ONE;
        addr_q <= addr_q + sext(s0_q);
      end else if (!last1) begin
        i0     <= '0;
        i1     <= i1 + LEN_ONE;
        addr_q <= addr_q + sext(s1_q);
      end else if (!last2) begin
        i0     <= '0;
        i1     <= '0;
        i2     <= i2 + LEN_ONE;
        addr_q <= addr_q + sext(s2_q);
      end else begin
        i0     <= '0;
        i1     <= '0;
        i2     <= '0;
        addr_q <= base_q;
      end
    end
  end

  assign addr_en  = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign addr_out = addr_q;
  assign loop_end = addr_en ? {last2, last1, last0} : 3'b000;

endmodule

// File: tb/tb_mvu_agu.sv
// Self-checking bench for mvu_agu: directed scenarios plus randomized jobs compared
// against a closed-form model of the nested-loop address pattern.
module tb_mvu_agu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  baseaddr;
  logic [14:0] stride_0, stride_1, stride_2;
  logic [14:0] length_0, length_1, length_2;
  logic [28:0] countdown;
  logic        addr_en;
  logic        addr_grnt;
  logic [8:0]  addr_out;
  logic [2:0]  loop_end;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  int m_base;
  int m_s[3];
  int m_l[3];

  mvu_agu #(.BADDR(9), .BSTRIDE(15), .BLENGTH(15), .BCNTDWN(29)) dut (
    .clk(clk), .rst(rst), .start(start), .baseaddr(baseaddr),
    .stride_0(stride_0), .stride_1(stride_1), .stride_2(stride_2),
    .length_0(length_0), .length_1(length_1), .length_2(length_2),
    .countdown(countdown), .addr_en(addr_en), .addr_grnt(addr_grnt),
    .addr_out(addr_out), .loop_end(loop_end), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Position p inside one full nest period: level-0 advanced p-q times, level-1 q-i2 times, level-2 i2 times.
  task automatic modelAt(input int k, output int ea, output int ele);
    int n0, n1, n2, p, q, i0, i1, i2, e0, e1, e2;
    n0 = m_l[0] + 1;
    n1 = m_l[1] + 1;
    n2 = m_l[2] + 1;
    p  = k % (n0 * n1 * n2);
    i0 = p % n0;
    q  = p / n0;
    i1 = q % n1;
    i2 = q / n1;
    ea = (m_base + (p - q) * m_s[0] + (q - i2) * m_s[1] + i2 * m_s[2]) & 511;
    e0 = (i0 == m_l[0]) ? 1 : 0;
    e1 = (e0 == 1 && i1 == m_l[1]) ? 1 : 0;
    e2 = (e1 == 1 && i2 == m_l[2]) ? 1 : 0;
    ele = e0 + 2 * e1 + 4 * e2;
  endtask

  task automatic applyStimulus(input int b, input int s0, input int s1, input int s2,
                               input int l0, input int l1, input int l2, input int cd);
    baseaddr  = b[8:0];
    stride_0  = s0[14:0];
    stride_1  = s1[14:0];
    stride_2  = s2[14:0];
    length_0  = l0[14:0];
    length_1  = l1[14:0];
    length_2  = l2[14:0];
    countdown = cd[28:0];
    m_base = b;
    m_s[0] = s0; m_s[1] = s1; m_s[2] = s2;
    m_l[0] = l0; m_l[1] = l1; m_l[2] = l2;
    start = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".addr_en"}, 32'(addr_en), 0);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".loop_end"}, 32'(loop_end), 0);
  endtask

  // gmode: 0 = grant always, 1 = grant pattern 1,0,0, 2 = random grant.
  task automatic runJob(input string tag, input int b, input int s0, input int s1, input int s2,
                        input int l0, input int l1, input int l2, input int cd,
                        input int gmode, input bit hold, input bit poke_done, input int abort_after);
    int k, cyc, ea, ele;
    bit g;
    applyStimulus(b, s0, s1, s2, l0, l1, l2, cd);
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    baseaddr  = 9'($urandom);
    stride_0  = 15'($urandom);
    stride_1  = 15'($urandom);
    stride_2  = 15'($urandom);
    length_0  = 15'($urandom);
    length_1  = 15'($urandom);
    length_2  = 15'($urandom);
    countdown = 29'($urandom);
    k = 0;
    cyc = 0;
    while (k < cd && cyc < 4 * cd + 20) begin
      if (abort_after > 0 && k == abort_after) begin
        rst = 1'b1;
        addr_grnt = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle({tag, ".rst"});
        checkOutput({tag, ".rst.addr_out"}, 32'(addr_out), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle({tag, ".after_rst"});
        return;
      end
      modelAt(k, ea, ele);
      checkOutput({tag, ".addr_en"}, 32'(addr_en), 1);
      checkOutput({tag, ".busy"}, 32'(busy), 1);
      checkOutput({tag, ".done_run"}, 32'(done), 0);
      checkOutput({tag, ".addr_out"}, 32'(addr_out), 32'(ea));
      checkOutput({tag, ".loop_end"}, 32'(loop_end), 32'(ele));
      case (gmode)
        0:       g = 1'b1;
        1:       g = (cyc % 3 == 0);
        default: g = ($urandom_range(0, 3) != 0);
      endcase
      addr_grnt = g;
      @(posedge clk);
      @(negedge clk);
      if (g) k++;
      cyc++;
    end
    if (k < cd) checkOutput({tag, ".cycle_budget"}, 32'(k), 32'(cd));
    addr_grnt = 1'b0;
    start = poke_done;
    checkOutput({tag, ".done"}, 32'(done), 1);
    checkOutput({tag, ".done_busy"}, 32'(busy), 0);
    checkOutput({tag, ".done_addr_en"}, 32'(addr_en), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkIdle({tag, ".bubble"});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    addr_grnt = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset.addr_out", 32'(addr_out), 0);
    rst = 1'b0;
    @(negedge clk);

    runJob("walk3d", 100, 1, 10, -20, 2, 1, 1, 12, 0, 1'b0, 1'b0, 0);
    runJob("nest_repeat", 5, 1, 0, 0, 1, 0, 0, 5, 0, 1'b0, 1'b0, 0);
    runJob("backpressure", 100, 1, 10, -20, 2, 1, 1, 12, 1, 1'b0, 1'b0, 0);
    runJob("cd_zero", 77, 1, 2, 3, 1, 1, 1, 0, 0, 1'b0, 1'b0, 0);
    runJob("wrap", 510, 3, 0, 0, 3, 0, 0, 2, 0, 1'b0, 1'b0, 0);
    runJob("start_held", 5, 1, 0, 0, 1, 0, 0, 5, 0, 1'b1, 1'b0, 0);
    runJob("start_in_done", 40, 2, 7, 1, 1, 2, 0, 4, 0, 1'b0, 1'b1, 0);
    @(negedge clk);
    checkIdle("start_in_done.ignored");
    runJob("abort", 100, 1, 10, -20, 2, 1, 1, 12, 0, 1'b0, 1'b0, 4);
    runJob("restart", 100, 1, 10, -20, 2, 1, 1, 12, 0, 1'b0, 1'b0, 0);

    for (int j = 0; j < 30; j++) begin
      runJob("random",
             int'($urandom_range(0, 511)),
             int'($urandom_range(0, 600)) - 300,
             int'($urandom_range(0, 600)) - 300,
             int'($urandom_range(0, 600)) - 300,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 40)), 2, 1'b0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
